data_mem_arbiter: RTL

- Shares the single-port synchronous data RAM behind the memory stage between two requesters.
- Port A is the pipeline memory stage and has priority. Port B is the external loader/DMA, which preloads and reads back image data.
- Generates the pipeline stall when A loses arbitration, guarantees B forward progress through a starvation counter, and routes 1-cycle-latency read data back to its owner.

---
 rtl/data_mem_arbiter_if.sv | 46 ++++
 rtl/data_mem_arbiter.sv | 118 +++++++++++
 2 files changed

// File: rtl/data_mem_arbiter_if.sv
// Data-RAM arbiter bus: pipeline port A, loader port B, and the RAM issue path.
// slave = arbiter side, master = requesters and RAM side.
interface data_mem_arbiter_if #(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 10
);
    logic              a_req;
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              a_stall;
    logic              a_rvalid;
    logic [DATA_W-1:0] a_rdata;

    logic              b_req;
    logic              b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic              b_gnt;
    logic              b_rvalid;
    logic [DATA_W-1:0] b_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        input  b_req, b_we, b_addr, b_wdata,
        input  mem_rdata,
        output a_stall, a_rvalid, a_rdata,
        output b_gnt, b_rvalid, b_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        output b_req, b_we, b_addr, b_wdata,
        output mem_rdata,
        input  a_stall, a_rvalid, a_rdata,
        input  b_gnt, b_rvalid, b_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter for the single-port data RAM: pipeline A has priority,
// loader B is guaranteed progress by a starvation counter.
module data_mem_arbiter #(
    parameter int DATA_W   = 24,
    parameter int ADDR_W   = 10,
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    data_mem_arbiter_if.slave bus,
    output logic [CNT_W-1:0] conflict_cnt
);
    localparam logic [0:0] NORMAL  = 1'b0;
    localparam logic [0:0] FORCE_B = 1'b1;

    localparam logic [3:0] WAIT_MAX  = 4'(MAX_WAIT);
    localparam logic [3:0] WAIT_LAST = 4'(MAX_WAIT - 1);

    logic [0:0]       state_q, state_d;
    logic [3:0]       wait_q, wait_d;
    logic             a_rv_q, a_rv_d;
    logic             b_rv_q, b_rv_d;
    logic [CNT_W-1:0] conf_q, conf_d;

    logic              grant_a, grant_b;
    logic [ADDR_W-1:0] addr_sel;
    logic [DATA_W-1:0] wdata_sel;
    logic              we_sel;

    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        case (state_q)
            FORCE_B: begin
                grant_b = bus.b_req;
                grant_a = bus.a_req & ~bus.b_req;
            end
            default: begin
                grant_a = bus.a_req;
                grant_b = bus.b_req & ~bus.a_req;
            end
        endcase
    end

    always_comb begin
        we_sel    = 1'b0;
        addr_sel  = '0;
        wdata_sel = '0;
        unique case (1'b1)
            grant_a: begin
                we_sel    = bus.a_we;
                addr_sel  = bus.a_addr;
                wdata_sel = bus.a_wdata;
            end
            grant_b: begin
                we_sel    = bus.b_we;
                addr_sel  = bus.b_addr;
                wdata_sel = bus.b_wdata;
            end
            default: ;
        endcase
    end

    assign bus.mem_en    = grant_a | grant_b;
    assign bus.mem_we    = we_sel;
    assign bus.mem_addr  = addr_sel;
    assign bus.mem_wdata = wdata_sel;
    assign bus.a_stall   = bus.a_req & ~grant_a;
    assign bus.b_gnt     = grant_b;

    // Read owner tracked directly as the per-port rvalid for the next cycle.
    always_comb begin
        a_rv_d = grant_a & ~bus.a_we;
        b_rv_d = grant_b & ~bus.b_we;
    end

    always_comb begin
        state_d = NORMAL;
        wait_d  = wait_q;
        if (!bus.b_req || grant_b) begin
            wait_d = '0;
        end else begin
            if (wait_q < WAIT_MAX)
                wait_d = wait_q + 4'd1;
            if (state_q == NORMAL && wait_q == WAIT_LAST)
                state_d = FORCE_B;
        end
    end

    always_comb begin
        conf_d = conf_q;
        if (bus.a_req && bus.b_req && conf_q != '1)
            conf_d = conf_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= NORMAL;
            wait_q  <= '0;
            a_rv_q  <= 1'b0;
            b_rv_q  <= 1'b0;
            conf_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            a_rv_q  <= a_rv_d;
            b_rv_q  <= b_rv_d;
            conf_q  <= conf_d;
        end
    end

    assign bus.a_rvalid = a_rv_q;
    assign bus.b_rvalid = b_rv_q;
    assign bus.a_rdata  = bus.mem_rdata;
    assign bus.b_rdata  = bus.mem_rdata;
    assign conflict_cnt = conf_q;
endmodule
